// File: rtl/priority_encoder_scan.sv
// priority_encoder_scan
//   Clocked request scanner. Accepts an arbitrary request vector over a
//   valid/ready input, then emits the index of every set bit, one per output
//   handshake, lowest-first (LSB_FIRST=1) or highest-first (LSB_FIRST=0).
//
//   Optional feature macro: ENC_ZERO_REPORT_EN
//     defined   -> adds out_none; an accepted all-zero vector produces one
//                  beat with out_none=1, out_last=1, out_index=0.
//     undefined -> an accepted all-zero vector is silently dropped.
module priority_encoder_scan #(
  parameter  int IN_WIDTH  = 8,
  parameter  int LSB_FIRST = 1,
  localparam int OUT_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_lines,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
`ifdef ENC_ZERO_REPORT_EN
  ,
  output logic                 out_none
`endif
);

  // ZERO is only reachable when zero-vector reporting is compiled in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   pending_q, pending_d;
  logic                  active_q;
  logic [OUT_WIDTH-1:0]  enc_idx;
  logic [IN_WIDTH-1:0]   enc_mask;
  logic                  one_left;

  // Priority encode of pending: index and one-hot mask of the winning bit.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise synthesis infers a latch to hold the old value.
    enc_idx  = '0;
    enc_mask = '0;
    if (LSB_FIRST != 0) begin
      // Walk downwards so the lowest set bit is the last one written.
      for (int i = IN_WIDTH - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          enc_idx     = OUT_WIDTH'(i);
          enc_mask    = '0;
          enc_mask[i] = 1'b1;
        end
      end
    end else begin
      // Walk upwards so the highest set bit is the last one written.
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (pending_q[i]) begin
          enc_idx     = OUT_WIDTH'(i);
          enc_mask    = '0;
          enc_mask[i] = 1'b1;
        end
      end
    end
  end

  // Exactly one bit left means the current beat is the final one.
  assign one_left = (pending_q != '0) &&
                    ((pending_q & (pending_q - 1'b1)) == '0);

  // Next-state and handshake outputs; outputs idle at zero by default.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_index = '0;
    out_last  = 1'b0;
`ifdef ENC_ZERO_REPORT_EN
    out_none  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // active_q keeps in_ready low until the first edge out of reset.
        in_ready = active_q;
        if (in_valid && active_q) begin
          if (in_lines != '0) begin
            pending_d = in_lines;
            state_d   = SCAN;
          end else begin
`ifdef ENC_ZERO_REPORT_EN
            state_d = ZERO;
`else
            state_d = IDLE;
`endif
          end
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_index = enc_idx;
        out_last  = one_left;
        if (out_ready) begin
          pending_d = pending_q & ~enc_mask;
          if (one_left) state_d = IDLE;
        end
      end
      ZERO: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
`ifdef ENC_ZERO_REPORT_EN
        out_none  = 1'b1;
`endif
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_priority_encoder_scan.sv
// tb_priority_encoder_scan
//   Directed bench: an 8-bit LSB-first instance covers most scenarios, a
//   16-bit MSB-first instance covers the reversed priority order.
//   Stimulus and sampling both happen on the falling edge.
module tb_priority_encoder_scan;

  logic       clk = 1'b0;
  logic       rst_n;

  // 8-bit, LSB-first instance
  logic [7:0] in_lines;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out_index;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
`ifdef ENC_ZERO_REPORT_EN
  logic       out_none;
`endif

  // 16-bit, MSB-first instance
  logic [15:0] w_in_lines;
  logic        w_in_valid;
  logic        w_in_ready;
  logic [3:0]  w_out_index;
  logic        w_out_valid;
  logic        w_out_ready;
  logic        w_out_last;
`ifdef ENC_ZERO_REPORT_EN
  logic        w_out_none;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  priority_encoder_scan #(.IN_WIDTH(8), .LSB_FIRST(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_lines  (in_lines),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef ENC_ZERO_REPORT_EN
    ,
    .out_none  (out_none)
`endif
  );

  priority_encoder_scan #(.IN_WIDTH(16), .LSB_FIRST(0)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_lines  (w_in_lines),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .out_index (w_out_index),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_last  (w_out_last)
`ifdef ENC_ZERO_REPORT_EN
    ,
    .out_none  (w_out_none)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: through the rising edge, then to the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check the 8-bit output beat in one call.
  task automatic check_beat(input string tag, input logic v,
                            input logic [2:0] idx, input logic last);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".index"}, 32'(out_index), 32'(idx));
    check({tag, ".last"},  32'(out_last),  32'(last));
  endtask

  initial begin
    rst_n       = 1'b0;
    in_lines    = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    w_in_lines  = '0;
    w_in_valid  = 1'b0;
    w_out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check_beat("rst", 1'b0, 3'd0, 1'b0);
    check("rst.w_out_valid", 32'(w_out_valid), 32'd0);
`ifdef ENC_ZERO_REPORT_EN
    check("rst.out_none", 32'(out_none), 32'd0);
`endif
    rst_n = 1'b1;
    step();
    check("rel.in_ready", 32'(in_ready), 32'd1);
    check_beat("rel", 1'b0, 3'd0, 1'b0);

    // 10010010 with out_ready high: 1, 4, 7 on consecutive cycles
    in_lines = 8'b1001_0010;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1.in_ready", 32'(in_ready), 32'd0);
    check_beat("t1.b0", 1'b1, 3'd1, 1'b0);
`ifdef ENC_ZERO_REPORT_EN
    check("t1.out_none", 32'(out_none), 32'd0);
`endif
    step();
    check_beat("t1.b1", 1'b1, 3'd4, 1'b0);
    step();
    check_beat("t1.b2", 1'b1, 3'd7, 1'b1);
    step();
    check_beat("t1.idle", 1'b0, 3'd0, 1'b0);
    check("t1.in_ready", 32'(in_ready), 32'd1);

    // Same vector, consumer stalls three cycles on the second beat
    in_lines = 8'b1001_0010;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_beat("t2.b0", 1'b1, 3'd1, 1'b0);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_beat("t2.hold", 1'b1, 3'd4, 1'b0);
      step();
    end
    out_ready = 1'b1;
    check_beat("t2.b1", 1'b1, 3'd4, 1'b0);
    step();
    check_beat("t2.b2", 1'b1, 3'd7, 1'b1);
    step();
    check_beat("t2.idle", 1'b0, 3'd0, 1'b0);

    // 16-bit MSB-first: 8001 -> 15 then 0 (last)
    w_in_lines = 16'h8001;
    w_in_valid = 1'b1;
    step();
    w_in_valid = 1'b0;
    check("t3.b0.valid", 32'(w_out_valid), 32'd1);
    check("t3.b0.index", 32'(w_out_index), 32'd15);
    check("t3.b0.last",  32'(w_out_last),  32'd0);
    step();
    check("t3.b1.valid", 32'(w_out_valid), 32'd1);
    check("t3.b1.index", 32'(w_out_index), 32'd0);
    check("t3.b1.last",  32'(w_out_last),  32'd1);
    step();
    check("t3.idle.valid", 32'(w_out_valid), 32'd0);
    check("t3.idle.in_ready", 32'(w_in_ready), 32'd1);

    // Single-bit vector; a second vector offered during SCAN must wait
    in_lines = 8'b0000_0001;
    in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    in_lines  = 8'b0000_0100;
    check_beat("t4.b0", 1'b1, 3'd0, 1'b1);
    check("t4.busy", 32'(in_ready), 32'd0);
    step();
    check_beat("t4.hold", 1'b1, 3'd0, 1'b1);
    check("t4.busy2", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check_beat("t4.bubble", 1'b0, 3'd0, 1'b0);
    check("t4.in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_beat("t4.b1", 1'b1, 3'd2, 1'b1);
    step();
    check_beat("t4.idle", 1'b0, 3'd0, 1'b0);

    // Zero vector
    in_lines = 8'h00;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef ENC_ZERO_REPORT_EN
    check_beat("t5.none", 1'b1, 3'd0, 1'b1);
    check("t5.out_none", 32'(out_none), 32'd1);
    step();
    check_beat("t5.idle", 1'b0, 3'd0, 1'b0);
    check("t5.out_none0", 32'(out_none), 32'd0);
    check("t5.in_ready", 32'(in_ready), 32'd1);
`else
    check_beat("t5.drop", 1'b0, 3'd0, 1'b0);
    check("t5.in_ready", 32'(in_ready), 32'd1);
    step();
    check("t5.valid2", 32'(out_valid), 32'd0);
`endif

    // All-ones: eight indices in order, last only on the final one
    in_lines = 8'hFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_beat("t6.ones", 1'b1, 3'(i), (i == 7) ? 1'b1 : 1'b0);
      step();
    end
    check_beat("t6.idle", 1'b0, 3'd0, 1'b0);

    // All-ones, reset after three indices: nothing stale afterwards
    in_lines = 8'hFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_beat("t7.b0", 1'b1, 3'd0, 1'b0);
    step();
    check_beat("t7.b1", 1'b1, 3'd1, 1'b0);
    step();
    check_beat("t7.b2", 1'b1, 3'd2, 1'b0);
    rst_n = 1'b0;
    step();
    check_beat("t7.rst", 1'b0, 3'd0, 1'b0);
    check("t7.rst.in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step();
    check("t7.rel.in_ready", 32'(in_ready), 32'd1);
    check_beat("t7.rel", 1'b0, 3'd0, 1'b0);
    step();
    check_beat("t7.quiet", 1'b0, 3'd0, 1'b0);

    // Post-reset vector scans cleanly from a fresh pending register
    in_lines = 8'b0010_1000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_beat("t8.b0", 1'b1, 3'd3, 1'b0);
    step();
    check_beat("t8.b1", 1'b1, 3'd5, 1'b1);
    step();
    check_beat("t8.idle", 1'b0, 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
